line_sp_list: RTL and testbench
===============================

Name: line_sp_list

Overview:
- Per-scanline sprite buffer directly downstream of the OAM scan stage.
- During mode 2 it captures up to MAX_SPRITES hits in OAM order: sprite number, fine Y and X.
- During mode 3 it presents the entry whose X matches the pixel fetcher's current X, and retires it on a fetch-done handshake.
- Contents are cleared at the start of each mode 2.

Parameters:
- MAX_SPRITES, 10, number of entries per line (hardware limit of sprites per scanline).
- CNT_W, 4, width of the entry count; must satisfy 2**CNT_W > MAX_SPRITES.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- sp_enable  input  1  sprite layer enable (LCDC.1)
- mode  input  2  PPU mode (0 hblank, 1 vblank, 2 OAM scan, 3 transfer)
- line_sp_list_write  input  1  write strobe from the OAM scan stage, one cycle per hit
- sp_num  input  6  OAM index of the hit sprite
- fine_y  input  4  row within the sprite (0-15)
- sp_x  input  8  OAM X byte of the hit sprite, valid with the write strobe
- lx  input  8  fetcher X position in OAM X coordinates (screen X + 8)
- sp_fetch_done  input  1  fetcher has finished the presented sprite
- sp_fetch_req  output  1  a live entry matches lx
- sp_fetch_num  output  6  sp_num of the presented entry
- sp_fetch_fine_y  output  4  fine_y of the presented entry
- sp_count  output  CNT_W  number of entries captured this line
- sp_overflow  output  1  at least one hit was dropped this line because the list was full

Behaviour:
- Reset (asynchronous, reset_n=0):
  - All entry valid bits, sp_count, sp_overflow and the mode_prev register go to 0.
  - Entry payload registers go to 0.
  - All outputs are therefore 0.
- Clear:
  - mode_prev is registered each cycle.
  - A clear is a cycle with mode==2 and mode_prev!=2.
  - On clear: sp_count←0, all valid←0, sp_overflow←0.
- Write:
  - Condition: line_sp_list_write=1, mode==2 and sp_count<MAX_SPRITES.
  - Effect: entry[sp_count] ← {sp_num, fine_y, sp_x}, valid←1, sp_count←sp_count+1.
  - Write and clear in the same cycle: the clear applies first; the write lands in entry 0 and sp_count becomes 1.
- Full list:
  - A write with sp_count==MAX_SPRITES is discarded.
  - sp_overflow←1, sticky until the next clear.
  - sp_count saturates at MAX_SPRITES and never wraps.
- Writes outside mode 2 are ignored.
- Match (combinational, zero latency from entry registers and lx):
  - match[i] = valid[i] & (x[i]==lx) & (mode==3) & sp_enable.
  - sp_fetch_req = OR of all match bits.
  - The presented entry is the lowest-index match, i.e. OAM order priority.
  - sp_fetch_num and sp_fetch_fine_y carry that entry's fields; both are 0 when sp_fetch_req=0.
- Consume:
  - sp_fetch_done=1 with sp_fetch_req=1 clears valid of the presented entry at the clock edge.
  - The next same-X entry is presented in the following cycle.
  - sp_fetch_done with sp_fetch_req=0 is ignored.
- sp_x==0 entries never match (lx ≥ 0 only reaches them off-screen); they are stored and counted anyway.
- Leaving mode 3 keeps the entries and count; they hold until the next clear.
- sp_enable=0 only masks sp_fetch_req. Capture still follows line_sp_list_write, which upstream already gates.
- Reset mid-line: state is lost immediately; the list stays empty until the next write after reset release.

Optional Feature:
- Macro: LINE_SP_LIST_DROP_CNT_EN.
- When defined:
  - Adds output drop_count (6 bits), counting discarded hits this line.
  - Saturates at 63, resets to 0 on clear and on reset.
- When undefined:
  - No port, no register.
  - sp_overflow is the only overflow indication.

Test Plan:
- Reset, then enter mode 2 and write 3 hits (num 5/9/12, fine_y 2/0/15, x 8/8/40); mode 3, lx=8 → req=1, num=5, fine_y=2.
- Continue the first test: done pulse → next cycle num=9, fine_y=0; second done → req=0; lx=40 → num=12, fine_y=15.
- Write 12 hits in one mode 2 → sp_count=10, sp_overflow=1, hits 11-12 absent; with the macro defined, drop_count=2.
- Write strobe in the same cycle as the mode 1→2 transition while the list holds 10 entries from the previous line → sp_count=1, sp_overflow=0, entry 0 holds the new sprite.
- Mode 3 with sp_enable=0 and lx matching an entry → req=0; assert sp_enable=1 → req=1 in the same cycle; done pulse with req=0 → no state change.
- Assert reset_n=0 asynchronously mid mode 3 with req=1 → req, sp_count and sp_overflow drop to 0 before the next clk edge.

Source files
------------

// File: rtl/line_sp_list.sv
// Per-scanline sprite list: captures OAM scan hits in mode 2 and presents X matches to the fetcher in mode 3.
// Optional LINE_SP_LIST_DROP_CNT_EN adds a per-line count of dropped hits.
module line_sp_list #(
    parameter int MAX_SPRITES = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sp_enable,
    input  logic [1:0]       mode,
    input  logic             line_sp_list_write,
    input  logic [5:0]       sp_num,
    input  logic [3:0]       fine_y,
    input  logic [7:0]       sp_x,
    input  logic [7:0]       lx,
    input  logic             sp_fetch_done,
    output logic             sp_fetch_req,
    output logic [5:0]       sp_fetch_num,
    output logic [3:0]       sp_fetch_fine_y,
    output logic [CNT_W-1:0] sp_count,
    output logic             sp_overflow
`ifdef LINE_SP_LIST_DROP_CNT_EN
    ,
    output logic [5:0]       drop_count
`endif
);

    localparam logic [CNT_W-1:0] LP_MAX    = CNT_W'(MAX_SPRITES);
    localparam logic [1:0]       MODE_OAM  = 2'd2;
    localparam logic [1:0]       MODE_XFER = 2'd3;

    logic [5:0]             r_num [MAX_SPRITES];
    logic [3:0]             r_fy  [MAX_SPRITES];
    logic [7:0]             r_x   [MAX_SPRITES];
    logic [MAX_SPRITES-1:0] r_valid;
    logic [CNT_W-1:0]       r_count;
    logic                   r_ovf;
    logic [1:0]             r_mode_prev;

    logic                   w_clear;
    logic [CNT_W-1:0]       w_base;
    logic                   w_wr_ok;
    logic                   w_wr_drop;
    logic [MAX_SPRITES-1:0] w_match;
    logic [CNT_W-1:0]       w_sel;
    logic [5:0]             w_hit_num;
    logic [3:0]             w_hit_fy;

    // A clear on the same cycle as a write means the write lands at entry 0.
    assign w_clear   = (mode == MODE_OAM) && (r_mode_prev != MODE_OAM);
    assign w_base    = w_clear ? '0 : r_count;
    assign w_wr_ok   = line_sp_list_write && (mode == MODE_OAM) && (w_base < LP_MAX);
    assign w_wr_drop = line_sp_list_write && (mode == MODE_OAM) && (w_base >= LP_MAX);

    // Descending scan so the lowest-index match (OAM order) wins.
    always_comb begin
        w_match   = '0;
        w_sel     = '0;
        w_hit_num = '0;
        w_hit_fy  = '0;
        for (int i = 0; i < MAX_SPRITES; i++) begin
            w_match[i] = r_valid[i] && (r_x[i] == lx) && (r_x[i] != 8'd0)
                         && (mode == MODE_XFER) && sp_enable;
        end
        for (int i = MAX_SPRITES - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_sel     = CNT_W'(i);
                w_hit_num = r_num[i];
                w_hit_fy  = r_fy[i];
            end
        end
    end

    assign sp_fetch_req    = |w_match;
    assign sp_fetch_num    = w_hit_num;
    assign sp_fetch_fine_y = w_hit_fy;
    assign sp_count        = r_count;
    assign sp_overflow     = r_ovf;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid     <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_mode_prev <= 2'd0;
        end else begin
            r_mode_prev <= mode;
            if (w_clear) begin
                r_valid <= '0;
            end else if (sp_fetch_done && sp_fetch_req) begin
                r_valid[w_sel] <= 1'b0;
            end
            if (w_wr_ok) begin
                r_valid[w_base] <= 1'b1;
            end
            r_count <= w_wr_ok ? (w_base + 1'b1) : w_base;
            r_ovf   <= w_clear ? 1'b0 : (r_ovf | w_wr_drop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_SPRITES; i++) begin
                r_num[i] <= '0;
                r_fy[i]  <= '0;
                r_x[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_SPRITES; i++) begin
                if (w_wr_ok && (w_base == CNT_W'(i))) begin
                    r_num[i] <= sp_num;
                    r_fy[i]  <= fine_y;
                    r_x[i]   <= sp_x;
                end
            end
        end
    end

`ifdef LINE_SP_LIST_DROP_CNT_EN
    logic [5:0] r_drop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop <= '0;
        end else if (w_clear) begin
            r_drop <= '0;
        end else if (w_wr_drop && (r_drop != 6'd63)) begin
            r_drop <= r_drop + 6'd1;
        end
    end

    assign drop_count = r_drop;
`endif

endmodule

// File: tb/tb_line_sp_list.sv
// Directed bench for line_sp_list: capture, OAM-order presentation, consume, overflow, clear and async reset.
module tb_line_sp_list;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sp_enable;
    logic [1:0] mode;
    logic       line_sp_list_write;
    logic [5:0] sp_num;
    logic [3:0] fine_y;
    logic [7:0] sp_x;
    logic [7:0] lx;
    logic       sp_fetch_done;
    logic       sp_fetch_req;
    logic [5:0] sp_fetch_num;
    logic [3:0] sp_fetch_fine_y;
    logic [3:0] sp_count;
    logic       sp_overflow;
`ifdef LINE_SP_LIST_DROP_CNT_EN
    logic [5:0] drop_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    line_sp_list #(.MAX_SPRITES(10), .CNT_W(4)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .sp_enable          (sp_enable),
        .mode               (mode),
        .line_sp_list_write (line_sp_list_write),
        .sp_num             (sp_num),
        .fine_y             (fine_y),
        .sp_x               (sp_x),
        .lx                 (lx),
        .sp_fetch_done      (sp_fetch_done),
        .sp_fetch_req       (sp_fetch_req),
        .sp_fetch_num       (sp_fetch_num),
        .sp_fetch_fine_y    (sp_fetch_fine_y),
        .sp_count           (sp_count),
        .sp_overflow        (sp_overflow)
`ifdef LINE_SP_LIST_DROP_CNT_EN
        ,
        .drop_count         (drop_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One hit per cycle, strobe driven from the falling edge.
    task automatic write_hit(input logic [5:0] n, input logic [3:0] fy, input logic [7:0] x);
        @(negedge clk);
        line_sp_list_write = 1'b1;
        sp_num = n;
        fine_y = fy;
        sp_x   = x;
    endtask

    task automatic step();
        @(negedge clk);
        line_sp_list_write = 1'b0;
        sp_fetch_done      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        sp_enable = 1'b1;
        mode = 2'd0;
        line_sp_list_write = 1'b0;
        sp_num = '0;
        fine_y = '0;
        sp_x = '0;
        lx = '0;
        sp_fetch_done = 1'b0;

        #12;
        check("rst_req", sp_fetch_req, 0);
        check("rst_num", sp_fetch_num, 0);
        check("rst_fy", sp_fetch_fine_y, 0);
        check("rst_cnt", sp_count, 0);
        check("rst_ovf", sp_overflow, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Line 1: three hits, two sharing X=8.
        @(negedge clk);
        mode = 2'd2;
        write_hit(6'd5, 4'd2, 8'd8);
        write_hit(6'd9, 4'd0, 8'd8);
        write_hit(6'd12, 4'd15, 8'd40);
        step();
        #1;
        check("l1_cnt", sp_count, 3);
        check("l1_ovf", sp_overflow, 0);
        mode = 2'd3;
        lx = 8'd8;
        #1;
        check("l1_req_a", sp_fetch_req, 1);
        check("l1_num_a", sp_fetch_num, 5);
        check("l1_fy_a", sp_fetch_fine_y, 2);
        sp_fetch_done = 1'b1;
        step();
        #1;
        check("l1_req_b", sp_fetch_req, 1);
        check("l1_num_b", sp_fetch_num, 9);
        check("l1_fy_b", sp_fetch_fine_y, 0);
        sp_fetch_done = 1'b1;
        step();
        #1;
        check("l1_req_c", sp_fetch_req, 0);
        check("l1_num_c", sp_fetch_num, 0);
        lx = 8'd40;
        #1;
        check("l1_req_d", sp_fetch_req, 1);
        check("l1_num_d", sp_fetch_num, 12);
        check("l1_fy_d", sp_fetch_fine_y, 15);
        lx = 8'd41;
        #1;
        check("l1_req_e", sp_fetch_req, 0);

        // Line 2: twelve hits, first one at X=0, last two dropped.
        step();
        mode = 2'd0;
        step();
        mode = 2'd2;
        for (int i = 0; i < 12; i++) begin
            write_hit(6'(20 + i), 4'(i), (i == 0) ? 8'd0 : 8'(50 + i));
        end
        step();
        #1;
        check("l2_cnt", sp_count, 10);
        check("l2_ovf", sp_overflow, 1);
`ifdef LINE_SP_LIST_DROP_CNT_EN
        check("l2_drop", drop_count, 2);
`endif
        mode = 2'd3;
        lx = 8'd0;
        #1;
        check("l2_x0_req", sp_fetch_req, 0);
        lx = 8'd60;
        #1;
        check("l2_hit11_req", sp_fetch_req, 0);
        lx = 8'd61;
        #1;
        check("l2_hit12_req", sp_fetch_req, 0);
        lx = 8'd59;
        #1;
        check("l2_last_req", sp_fetch_req, 1);
        check("l2_last_num", sp_fetch_num, 29);
        check("l2_last_fy", sp_fetch_fine_y, 9);

        // Asynchronous reset mid mode 3, well before the next rising edge.
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_req", sp_fetch_req, 0);
        check("arst_cnt", sp_count, 0);
        check("arst_ovf", sp_overflow, 0);
        step();
        reset_n = 1'b1;
        step();
        #1;
        check("post_rst_req", sp_fetch_req, 0);

        // Refill ten entries, then a mode 1->2 transition with a write strobe.
        mode = 2'd0;
        step();
        mode = 2'd2;
        for (int i = 0; i < 10; i++) begin
            write_hit(6'(40 + i), 4'd1, 8'(100 + i));
        end
        write_hit(6'd50, 4'd1, 8'd120);
        step();
        #1;
        check("l3_cnt", sp_count, 10);
        check("l3_ovf", sp_overflow, 1);
        mode = 2'd1;
        step();
        write_hit(6'd33, 4'd7, 8'd77);
        mode = 2'd2;
        step();
        #1;
        check("l4_cnt", sp_count, 1);
        check("l4_ovf", sp_overflow, 0);
`ifdef LINE_SP_LIST_DROP_CNT_EN
        check("l4_drop", drop_count, 0);
`endif
        mode = 2'd3;
        lx = 8'd77;
        #1;
        check("l4_req", sp_fetch_req, 1);
        check("l4_num", sp_fetch_num, 33);
        check("l4_fy", sp_fetch_fine_y, 7);
        lx = 8'd100;
        #1;
        check("l4_old_req", sp_fetch_req, 0);

        // Enable masking and a done pulse while nothing is presented.
        lx = 8'd77;
        sp_enable = 1'b0;
        #1;
        check("en0_req", sp_fetch_req, 0);
        check("en0_num", sp_fetch_num, 0);
        sp_enable = 1'b1;
        #1;
        check("en1_req", sp_fetch_req, 1);
        sp_enable = 1'b0;
        sp_fetch_done = 1'b1;
        step();
        sp_enable = 1'b1;
        #1;
        check("idle_done_req", sp_fetch_req, 1);
        check("idle_done_num", sp_fetch_num, 33);
        check("idle_done_cnt", sp_count, 1);

        // Leaving mode 3 keeps the list.
        mode = 2'd0;
        step();
        step();
        #1;
        check("hold_cnt", sp_count, 1);
        mode = 2'd3;
        #1;
        check("hold_req", sp_fetch_req, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
